// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: segment type, digit patterns, decoder.
// Segment order is {a,b,c,d,e,f,g}, 1 = lit, before any polarity flip.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b1111110;
  localparam seg7_t SEG_1     = 7'b0110000;
  localparam seg7_t SEG_2     = 7'b1101101;
  localparam seg7_t SEG_3     = 7'b1111001;
  localparam seg7_t SEG_4     = 7'b0110011;
  localparam seg7_t SEG_5     = 7'b1011011;
  localparam seg7_t SEG_6     = 7'b1011111;
  localparam seg7_t SEG_7     = 7'b1110000;
  localparam seg7_t SEG_8     = 7'b1111111;
  localparam seg7_t SEG_9     = 7'b1111011;
  localparam seg7_t SEG_BLANK = 7'b0000000;

  function automatic seg7_t seg7_decode(input logic [3:0] bcd);
    seg7_t s;
    case (bcd)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_digit_decode.sv
// Combinational BCD to 7-segment decoder with a forced-blank input.
// Ports: bcd (4b code), blank (1 = dark), seg ({a..g}, 1 = lit).
module seg7_digit_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] seg
);

  assign seg = blank ? SEG_BLANK : seg7_decode(bcd);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed multi-digit 7-segment driver with blanking features.
// Ports: clk, rst_n (async low), bcd_in/dp_in/load (shadow capture),
// enable (scan on), seg/dp/an (registered pins), digit_idx (scan index).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int PRESCALE       = 50000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0,
  parameter int BLANK_LZ       = 1,
  localparam int IDX_W =
    (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [IDX_W-1:0]        digit_idx
);

  localparam int PRE_W = $clog2(PRESCALE);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
  localparam logic AN_INV = (AN_ACTIVE_LOW != 0);
  localparam logic LZ_EN = (BLANK_LZ != 0);
  localparam logic [PRE_W-1:0] PRE_LAST =
    PRE_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST =
    IDX_W'(NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [NUM_DIGITS-1:0]   dpr_q;
  logic [PRE_W-1:0]        presc;

  logic [NUM_DIGITS-1:0]   lz;
  logic [3:0]              sel_bcd;
  logic                    sel_dp;
  logic                    sel_blank;
  logic [NUM_DIGITS-1:0]   sel_an;
  logic [6:0]              dec_seg;
  logic                    lit;
  logic [6:0]              seg_n;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_q <= '0;
      dpr_q <= '0;
    end else if (load) begin
      bcd_q <= bcd_in;
      dpr_q <= dp_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc     <= '0;
      digit_idx <= '0;
    end else if (!enable) begin
      presc     <= '0;
      digit_idx <= '0;
    end else if (presc == PRE_LAST) begin
      presc     <= '0;
      digit_idx <= (digit_idx == IDX_LAST) ?
                   '0 : digit_idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Walk from the MSD down; a digit is a leading zero while
  // everything above it (and itself) is code 0. Digit 0 never blanks.
  always_comb begin
    logic za;
    lz = '0;
    za = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (bcd_q[4*i +: 4] != 4'd0)
        za = 1'b0;
      lz[i] = za && (i != 0);
    end
  end

  always_comb begin
    sel_bcd   = '0;
    sel_dp    = 1'b0;
    sel_blank = 1'b0;
    sel_an    = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        sel_bcd   = bcd_q[4*i +: 4];
        sel_dp    = dpr_q[i];
        sel_blank = lz[i] && LZ_EN;
        sel_an[i] = 1'b1;
      end
    end
  end

  seg7_digit_decode u_dec (
    .bcd   (sel_bcd),
    .blank (sel_blank),
    .seg   (dec_seg)
  );

  // Count 0 of each slot is the anti-ghosting dark cycle.
  assign lit   = enable && (presc != '0);
  assign seg_n = lit ? dec_seg : SEG_BLANK;
  assign dp_n  = lit && sel_dp;
  assign an_n  = lit ? sel_an : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= {7{SEG_INV}};
      dp  <= SEG_INV;
      an  <= {NUM_DIGITS{AN_INV}};
    end else begin
      seg <= seg_n ^ {7{SEG_INV}};
      dp  <= dp_n ^ SEG_INV;
      an  <= an_n ^ {NUM_DIGITS{AN_INV}};
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: cycle scoreboard plus directed steps.
// Three instances share stimulus: default, no LZ blanking, active-low.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] bcd_in = '0;
  logic [3:0]  dp_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b1;

  logic [6:0] seg_a, seg_b, seg_p;
  logic       dp_a, dp_b, dp_p;
  logic [3:0] an_a, an_b, an_p;
  logic [1:0] idx_a, idx_b, idx_p;

  int n_checks = 0;
  int n_err = 0;

  initial forever #5 clk = ~clk;

  seg7_scan_driver #(
    .NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW(0), .BLANK_LZ(1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in),
    .load(load), .enable(enable), .seg(seg_a), .dp(dp_a),
    .an(an_a), .digit_idx(idx_a)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(0),
    .AN_ACTIVE_LOW(0), .BLANK_LZ(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in),
    .load(load), .enable(enable), .seg(seg_b), .dp(dp_b),
    .an(an_b), .digit_idx(idx_b)
  );

  seg7_scan_driver #(
    .NUM_DIGITS(4), .PRESCALE(4), .SEG_ACTIVE_LOW(1),
    .AN_ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut_p (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .dp_in(dp_in),
    .load(load), .enable(enable), .seg(seg_p), .dp(dp_p),
    .an(an_p), .digit_idx(idx_p)
  );

  localparam logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
    7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000
  };

  typedef struct packed {
    logic [6:0] seg_a;
    logic       dp;
    logic [3:0] an;
    logic [6:0] seg_b;
  } exp_t;

  exp_t sbq[$];
  exp_t ce;

  logic [1:0]  m_presc, m_idx;
  logic [15:0] m_sh;
  logic [3:0]  m_shd;

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bound(input string tag, input int n);
    n_checks++;
    assert (n < 64) else begin
      n_err++;
      $error("FAIL %s: timeout after %0d cycles want <64",
             tag, n);
    end
  endtask

  function automatic exp_t model_out(input logic [1:0] pr,
                                     input logic [1:0] ix,
                                     input logic [15:0] sh,
                                     input logic [3:0] shd,
                                     input logic en);
    exp_t e;
    logic [3:0] code;
    logic za;
    e = '0;
    if (en && pr != 2'd0) begin
      code = sh[ix*4 +: 4];
      e.an = 4'b0001 << ix;
      e.dp = shd[ix];
      e.seg_b = PAT[code];
      e.seg_a = PAT[code];
      za = 1'b1;
      for (int j = 0; j < 4; j++)
        if (j >= int'(ix) && sh[j*4 +: 4] != 4'd0)
          za = 1'b0;
      if (ix != 2'd0 && za)
        e.seg_a = 7'b0000000;
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_presc <= '0;
      m_idx <= '0;
      m_sh <= '0;
      m_shd <= '0;
      sbq.delete();
    end else begin
      sbq.push_back(model_out(m_presc, m_idx, m_sh, m_shd,
                              enable));
      if (!enable) begin
        m_presc <= '0;
        m_idx <= '0;
      end else if (m_presc == 2'd3) begin
        m_presc <= '0;
        m_idx <= m_idx + 2'd1;
      end else begin
        m_presc <= m_presc + 2'd1;
      end
      if (load) begin
        m_sh <= bcd_in;
        m_shd <= dp_in;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      chk("sb_idx", {6'b0, idx_a}, {6'b0, m_idx});
      if (sbq.size() > 0) begin
        ce = sbq.pop_front();
        chk("sb_seg", {1'b0, seg_a}, {1'b0, ce.seg_a});
        chk("sb_dp", {7'b0, dp_a}, {7'b0, ce.dp});
        chk("sb_an", {4'b0, an_a}, {4'b0, ce.an});
        chk("sb_seg_nolz", {1'b0, seg_b}, {1'b0, ce.seg_b});
        chk("sb_seg_pol", {1'b0, seg_p}, {1'b0, ~ce.seg_a});
        chk("sb_dp_pol", {7'b0, dp_p}, {7'b0, ~ce.dp});
        chk("sb_an_pol", {4'b0, an_p}, {4'b0, ~ce.an});
      end
    end
  end

  task automatic do_load(input logic [15:0] b,
                         input logic [3:0] d);
    @(negedge clk);
    bcd_in = b;
    dp_in = d;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic expect_digit(input string tag,
                              input logic [3:0] an_e,
                              input logic [6:0] seg_e,
                              input logic dp_e,
                              input logic [6:0] segb_e);
    int n = 0;
    while (an_a !== 4'b0000 && n < 64) begin
      @(negedge clk);
      n++;
    end
    while (an_a !== an_e && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk_bound({tag, "_wait"}, n);
    chk({tag, "_seg"}, {1'b0, seg_a}, {1'b0, seg_e});
    chk({tag, "_dp"}, {7'b0, dp_a}, {7'b0, dp_e});
    chk({tag, "_seg_nolz"}, {1'b0, seg_b}, {1'b0, segb_e});
    chk({tag, "_seg_pol"}, {1'b0, seg_p}, {1'b0, ~seg_e});
    chk({tag, "_an_pol"}, {4'b0, an_p}, {4'b0, ~an_e});
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_seg"}, {1'b0, seg_a}, 8'h00);
    chk({tag, "_dp"}, {7'b0, dp_a}, 8'h00);
    chk({tag, "_an"}, {4'b0, an_a}, 8'h00);
    chk({tag, "_idx"}, {6'b0, idx_a}, 8'h00);
    chk({tag, "_seg_pol"}, {1'b0, seg_p}, 8'h7f);
    chk({tag, "_dp_pol"}, {7'b0, dp_p}, 8'h01);
    chk({tag, "_an_pol"}, {4'b0, an_p}, 8'h0f);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check_dark("rst");
    @(negedge clk);
    rst_n = 1'b1;
    expect_digit("rst_d0", 4'b0001, 7'b1111110, 1'b0,
                 7'b1111110);

    do_load(16'h1234, 4'b0000);
    expect_digit("s_d0", 4'b0001, 7'b0110011, 1'b0, 7'b0110011);
    expect_digit("s_d1", 4'b0010, 7'b1111001, 1'b0, 7'b1111001);
    expect_digit("s_d2", 4'b0100, 7'b1101101, 1'b0, 7'b1101101);
    expect_digit("s_d3", 4'b1000, 7'b0110000, 1'b0, 7'b0110000);

    do_load(16'h0070, 4'b1000);
    expect_digit("lz_d3", 4'b1000, 7'b0000000, 1'b1, 7'b1111110);
    expect_digit("lz_d0", 4'b0001, 7'b1111110, 1'b0, 7'b1111110);
    expect_digit("lz_d1", 4'b0010, 7'b1110000, 1'b0, 7'b1110000);
    expect_digit("lz_d2", 4'b0100, 7'b0000000, 1'b0, 7'b1111110);

    do_load(16'hA0F5, 4'b0000);
    expect_digit("inv_d3", 4'b1000, 7'b0000000, 1'b0, 7'b0000000);
    expect_digit("inv_d0", 4'b0001, 7'b1011011, 1'b0, 7'b1011011);
    expect_digit("inv_d1", 4'b0010, 7'b0000000, 1'b0, 7'b0000000);
    expect_digit("inv_d2", 4'b0100, 7'b1111110, 1'b0, 7'b1111110);

    do_load(16'h8888, 4'b0100);
    expect_digit("pol_d2", 4'b0100, 7'b1111111, 1'b1, 7'b1111111);
    chk("pol_dp", {7'b0, dp_p}, 8'h00);

    expect_digit("mid_d1", 4'b0010, 7'b1111111, 1'b0, 7'b1111111);
    #2 rst_n = 1'b0;
    #1 check_dark("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    expect_digit("mid_d0", 4'b0001, 7'b1111110, 1'b0, 7'b1111110);

    do_load(16'h1234, 4'b0000);
    expect_digit("en_d2", 4'b0100, 7'b1101101, 1'b0, 7'b1101101);
    enable = 1'b0;
    @(posedge clk);
    #1 check_dark("en_off");
    repeat (3) @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (an_a === 4'b0000 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk_bound("en_restart_wait", n);
    chk("en_restart_an", {4'b0, an_a}, 8'h01);
    chk("en_restart_seg", {1'b0, seg_a}, {1'b0, 7'b0110011});

    n = 0;
    while (!(m_presc == 2'd3 && m_idx == 2'd1) && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk_bound("race_wait", n);
    bcd_in = 16'h9999;
    dp_in = 4'b0000;
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
    chk("race_old_an", {4'b0, an_a}, 8'h02);
    chk("race_old_seg", {1'b0, seg_a}, {1'b0, 7'b1111001});
    @(negedge clk);
    chk("race_blank_an", {4'b0, an_a}, 8'h00);
    @(negedge clk);
    chk("race_new_an", {4'b0, an_a}, 8'h04);
    chk("race_new_seg", {1'b0, seg_a}, {1'b0, 7'b1111011});

    repeat (8) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
